// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : cpu16 instruction fetch stage. Owns the fetch PC, drives the
//                combinational ROM address, captures {pc, instr} pairs into a
//                small circular prefetch FIFO and presents the head to decode
//                over a valid/ready handshake. A redirect flushes the FIFO
//                and reloads the PC.
//  Ports       : clk, rst_n (async active-low)
//                rom_addr/rom_data      - combinational ROM interface
//                fetch_en               - allow new pushes
//                instr/instr_pc/instr_valid/instr_ready - decode handshake
//                redirect/redirect_pc   - flush and reload fetch PC
//                fifo_level             - current entry count
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [15:0]              rom_addr,
    input  logic [15:0]              rom_data,
    input  logic                     fetch_en,
    output logic [15:0]              instr,
    output logic [15:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int                  c_PW    = $clog2(DEPTH);
    localparam logic [c_PW:0]       c_DEPTH = (c_PW + 1)'(DEPTH);
    localparam logic [c_PW-1:0]     c_PONE  = c_PW'(1);

    logic [15:0]      r_fetch_pc;
    logic [31:0]      r_mem [DEPTH];   // {pc, instr}
    logic [c_PW-1:0]  r_head;
    logic [c_PW-1:0]  r_tail;
    logic [c_PW:0]    r_count;

    logic             w_nonempty;
    logic             w_pop;
    logic             w_push;
    logic [31:0]      w_head_entry;

    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && instr_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_push     = fetch_en && !redirect && ((r_count < c_DEPTH) || w_pop);

    assign w_head_entry = r_mem[r_head];

    assign rom_addr    = r_fetch_pc;
    assign instr_valid = w_nonempty;
    // Gate the head entry so an empty FIFO never exposes stale data.
    assign instr       = w_nonempty ? w_head_entry[15:0]  : 16'h0000;
    assign instr_pc    = w_nonempty ? w_head_entry[31:16] : 16'h0000;
    assign fifo_level  = r_count;

    // Storage needs no reset: entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {r_fetch_pc, rom_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            // Any pop this cycle is implicitly accepted; the flush discards
            // everything else.
            r_fetch_pc <= redirect_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 16'd1;
                r_tail     <= r_tail + c_PONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PW + 1)'(1);
                2'b01:   r_count <= r_count - (c_PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch with a small
//                combinational ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        fetch_en;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [1:0]  fifo_level;

    int checks;
    int errors;

    instr_fetch #(
        .RESET_PC (16'h0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fetch_en    (fetch_en),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_level  (fifo_level)
    );

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: rom = 16'h70FF;
            16'h0001: rom = 16'h8002;
            16'h0002: rom = 16'h8001;
            16'h0003: rom = 16'h6BE8;
            16'h003C: rom = 16'hBE80;
            16'h003D: rom = 16'h0000;
            default:  rom = 16'h0000;
        endcase
    endfunction

    assign rom_data = rom(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc, input logic [15:0] ins);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"},    32'(instr_pc),    32'(pc));
        chk({tag, "_instr"}, 32'(instr),       32'(ins));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Reset state
        repeat (2) tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_level", 32'(fifo_level),  32'd0);
        chk("rst_instr", 32'(instr),       32'd0);
        chk("rst_pc",    32'(instr_pc),    32'd0);
        chk("rst_addr",  32'(rom_addr),    32'd0);

        // 1: streaming after reset release
        rst_n = 1'b1;
        tick();
        chk_head("t1_s0", 16'h0000, 16'h70FF);
        chk("t1_lvl0", 32'(fifo_level), 32'd1);
        tick();
        chk_head("t1_s1", 16'h0001, 16'h8002);
        chk("t1_lvl1", 32'(fifo_level), 32'd1);
        tick();
        chk_head("t1_s2", 16'h0002, 16'h8001);
        tick();
        chk_head("t1_s3", 16'h0003, 16'h6BE8);
        chk("t1_lvl3", 32'(fifo_level), 32'd1);

        // 2: backpressure saturates the FIFO
        #2 rst_n = 1'b0;
        #1 instr_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_head("t2_fill", 16'h0000, 16'h70FF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_lvl",  32'(fifo_level), 32'd2);
            chk("t2_addr", 32'(rom_addr),   32'h0002);
            chk_head("t2_hold", 16'h0000, 16'h70FF);
        end
        instr_ready = 1'b1;
        tick();
        chk_head("t2_d1", 16'h0001, 16'h8002);
        chk("t2_lvl_d1", 32'(fifo_level), 32'd2);
        tick();
        chk_head("t2_d2", 16'h0002, 16'h8001);
        chk("t2_lvl_d2", 32'(fifo_level), 32'd2);

        // 3: redirect from full FIFO
        redirect    = 1'b1;
        redirect_pc = 16'h003C;
        tick();
        redirect = 1'b0;
        chk("t3_bubble_valid", 32'(instr_valid), 32'd0);
        chk("t3_bubble_lvl",   32'(fifo_level),  32'd0);
        chk("t3_bubble_instr", 32'(instr),       32'd0);
        chk("t3_addr",         32'(rom_addr),    32'h003C);
        tick();
        chk_head("t3_s0", 16'h003C, 16'hBE80);
        tick();
        chk_head("t3_s1", 16'h003D, 16'h0000);

        // 4: PC wrap
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        chk("t4_bubble", 32'(instr_valid), 32'd0);
        tick();
        chk_head("t4_s0", 16'hFFFF, 16'h0000);
        tick();
        chk_head("t4_s1", 16'h0000, 16'h70FF);

        // 5: asynchronous reset mid-stream
        instr_ready = 1'b0;
        tick();
        chk("t5_lvl2", 32'(fifo_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(instr_valid), 32'd0);
        chk("t5_lvl",   32'(fifo_level),  32'd0);
        chk("t5_addr",  32'(rom_addr),    32'd0);
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        tick();
        chk_head("t5_restart", 16'h0000, 16'h70FF);

        // 6: fetch_en low drains and freezes the PC
        instr_ready = 1'b0;
        tick();
        chk("t6_lvl2", 32'(fifo_level), 32'd2);
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        chk_head("t6_h0", 16'h0000, 16'h70FF);
        tick();
        chk_head("t6_h1", 16'h0001, 16'h8002);
        chk("t6_lvl1", 32'(fifo_level), 32'd1);
        chk("t6_addr1", 32'(rom_addr), 32'h0002);
        tick();
        chk("t6_empty", 32'(instr_valid), 32'd0);
        chk("t6_lvl0",  32'(fifo_level),  32'd0);
        chk("t6_einst", 32'(instr),       32'd0);
        chk("t6_epc",   32'(instr_pc),    32'd0);
        tick();
        chk("t6_addr2", 32'(rom_addr),    32'h0002);
        chk("t6_idle",  32'(instr_valid), 32'd0);
        fetch_en = 1'b1;
        tick();
        chk_head("t6_resume", 16'h0002, 16'h8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the cpu16 core. It sits between the instruction ROM and the decode stage.
- It owns the program counter and drives the combinational ROM address. It captures the returned 16-bit instruction word the same cycle and buffers {pc, instr} pairs in a small prefetch FIFO.
- It presents those pairs to decode over a valid/ready handshake. Decode and branch resolution can redirect the PC; a redirect flushes the buffer.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  16  instruction ROM address; combinational copy of the fetch PC register.
- rom_data  in  16  ROM read data; combinational, valid in the same cycle as rom_addr.
- fetch_en  in  1  1 = fetching allowed; 0 = no new pushes.
- instr  out  16  instruction word at FIFO head.
- instr_pc  out  16  address of instr.
- instr_valid  out  1  FIFO non-empty.
- instr_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  flush and load redirect_pc.
- redirect_pc  in  16  new fetch address.
- fifo_level  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset, asynchronous on rst_n low, takes effect immediately:
  - fetch_pc = RESET_PC, FIFO empty, fifo_level = 0.
  - instr_valid = 0, instr = 16'h0000, instr_pc = 16'h0000.
- Addressing: rom_addr = fetch_pc at all times, including during reset.
- Pop: occurs when instr_valid && instr_ready. The head advances at the next edge.
- Push: occurs when fetch_en && !redirect && (fifo_level < DEPTH || pop). It writes {fetch_pc, rom_data} at the tail. fetch_pc <= fetch_pc + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- Simultaneous push and pop: allowed when full or partially full. fifo_level is unchanged and ordering is preserved.
- No push (FIFO full without pop, or fetch_en = 0): fetch_pc holds and rom_addr is stable.
- Redirect has highest priority:
  - At the edge, the FIFO is cleared, fifo_level = 0 and fetch_pc <= redirect_pc.
  - No push occurs that cycle. A pop handshake in the redirect cycle still counts as accepted by decode.
  - All other buffered entries are discarded.
- Latency:
  - Reset release to first instr_valid: 1 clock edge, since the push happens at the first edge after rst_n rises.
  - Redirect to valid: the redirect edge, then the push edge. The target is valid after the second edge, so there is exactly one bubble cycle with instr_valid = 0.
- Empty FIFO: instr and instr_pc drive 16'h0000. They never show stale entries.
- Stability: while instr_valid = 1 and instr_ready = 0, instr and instr_pc hold.
- Throughput: with instr_ready held high and no redirect, one instruction per cycle, sequential PCs, no gaps after the initial fill.
- FIFO implementation: a circular buffer with head/tail pointers of width $clog2(DEPTH) plus a count register. Pointers wrap naturally.
- fifo_level never exceeds DEPTH.

Test Plan:
1. Reset release, fetch_en = 1, instr_ready = 1 → instr_valid rises after the first edge. Required stream: (pc 0000, 70FF), (0001, 8002), (0002, 8001), (0003, 6BE8) on consecutive cycles; fifo_level stays 1.
2. After the first fill, instr_ready = 0 for 5 cycles → fifo_level saturates at 2 and rom_addr holds 0002. Head stays (0000, 70FF). Then instr_ready = 1 → 70FF, 8002, 8001 delivered in order, no drop and no duplicate.
3. FIFO full (2 entries), redirect = 1 with redirect_pc = 003C for one cycle → the next cycle has instr_valid = 0 and fifo_level = 0. The cycle after has (003C, BE80), then (003D, 0000).
4. Redirect to FFFF → instr stream (FFFF, 0000) then (0000, 70FF), proving the PC wrap.
5. Mid-stream with fifo_level = 2, assert rst_n low between clock edges → instr_valid = 0, fifo_level = 0 and rom_addr = 0000 immediately, without waiting for a clock. After release, the stream restarts at (0000, 70FF).
6. fetch_en = 0 with 2 entries buffered and instr_ready = 1 → both entries drain, then instr_valid = 0 and rom_addr frozen at 0002. Re-asserting fetch_en resumes with (0002, 8001).
